// File: rtl/z80_bus_pkg.sv
// ============================================================================
//  Package  : z80_bus_pkg
//  Brief    : Shared encodings for the Z80 I/O bus master (ops, FSM states,
//             automatic wait-state counts).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package z80_bus_pkg;

   localparam logic [1:0] OP_IORD = 2'b00;
   localparam logic [1:0] OP_IOWR = 2'b01;
   localparam logic [1:0] OP_INTA = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   localparam int TW_AUTO_IO   = 1;
   localparam int TW_AUTO_INTA = 2;
   localparam int TWC_W        = 5;

   // T4 is the one-cycle recovery after an INTA T3, before the response
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_T1   = 3'd1,
      ST_T2   = 3'd2,
      ST_TW   = 3'd3,
      ST_T3   = 3'd4,
      ST_T4   = 3'd5,
      ST_RSP  = 3'd6
   } state_t;

   function automatic logic [TWC_W-1:0] tw_total(input logic inta, input int n_wait);
      int total;
      total = (inta ? TW_AUTO_INTA : TW_AUTO_IO) + n_wait;
      return TWC_W'(total);
   endfunction

endpackage

`default_nettype wire

// File: rtl/z80_sync2.sv
// ============================================================================
//  Module   : z80_sync2
//  Brief    : Two-flop synchroniser, resets to 1 (idle level of int_n).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module z80_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

`default_nettype wire

// File: rtl/z80_io_master.sv
// ============================================================================
//  Module   : z80_io_master
//  Brief    : Z80 I/O read / write / IM2 INTA bus cycle generator driven by a
//             valid/ready request port. Optional macro Z80IO_WAIT_EN enables
//             wait_n extension of the last scheduled TW state.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module z80_io_master
   import z80_bus_pkg::*;
#(
   parameter int AWID   = 4,
   parameter int DWID   = 8,
   parameter int N_WAIT = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [1:0]      req_op,
   input  logic [AWID-1:0] req_addr,
   input  logic [DWID-1:0] req_wdata,
   output logic            rsp_valid,
   output logic [DWID-1:0] rsp_data,
   output logic            int_pending,
   output logic            m1_n,
   output logic            iorq_n,
   output logic            rd_n,
   output logic            wr_n,
   output logic [AWID-1:0] a,
   output logic [DWID-1:0] dout,
   output logic            dout_oe,
   input  logic [DWID-1:0] din,
   input  logic            int_n,
   input  logic            wait_n
);

   state_t           state;
   logic [1:0]       op_r;
   logic [TWC_W-1:0] twc;
   logic [TWC_W-1:0] tw_need;
   logic             wait_ok;
   logic             int_sync;

   assign req_ready   = (state == ST_IDLE);
   assign tw_need     = tw_total(op_r == OP_INTA, N_WAIT);
   assign int_pending = ~int_sync;

`ifdef Z80IO_WAIT_EN
   assign wait_ok = wait_n;
`else
   logic unused_wait;
   assign unused_wait = wait_n;
   assign wait_ok     = 1'b1;
`endif

   z80_sync2 u_int_sync (
      .clk   (clk),
      .reset (reset),
      .d     (int_n),
      .q     (int_sync)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         op_r      <= OP_IORD;
         twc       <= '0;
         m1_n      <= 1'b1;
         iorq_n    <= 1'b1;
         rd_n      <= 1'b1;
         wr_n      <= 1'b1;
         a         <= '0;
         dout      <= '0;
         dout_oe   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  op_r <= req_op;
                  case (req_op)
                     OP_RSVD: begin
                        state     <= ST_RSP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= '1;
                     end
                     OP_INTA: begin
                        state <= ST_T1;
                        m1_n  <= 1'b0;
                        a     <= '0;
                     end
                     OP_IOWR: begin
                        state   <= ST_T1;
                        a       <= req_addr;
                        dout    <= req_wdata;
                        dout_oe <= 1'b1;
                     end
                     default: begin
                        state <= ST_T1;
                        a     <= req_addr;
                     end
                  endcase
               end
            end
            ST_T1: begin
               state <= ST_T2;
               if (op_r != OP_INTA) begin
                  iorq_n <= 1'b0;
                  rd_n   <= (op_r != OP_IORD);
                  wr_n   <= (op_r != OP_IOWR);
               end
            end
            ST_T2: begin
               state <= ST_TW;
               twc   <= TWC_W'(1);
               if (op_r == OP_INTA) iorq_n <= 1'b0;
            end
            ST_TW: begin
               // Once the scheduled TWs are spent, wait_ok gates the move to T3
               if (twc >= tw_need && wait_ok) state <= ST_T3;
               if (twc != '1) twc <= twc + TWC_W'(1);
            end
            ST_T3: begin
               m1_n    <= 1'b1;
               iorq_n  <= 1'b1;
               rd_n    <= 1'b1;
               wr_n    <= 1'b1;
               dout_oe <= 1'b0;
               if (op_r == OP_INTA) begin
                  rsp_data <= din;
                  state    <= ST_T4;
               end else begin
                  rsp_data  <= (op_r == OP_IORD) ? din : '0;
                  rsp_valid <= 1'b1;
                  state     <= ST_RSP;
               end
            end
            ST_T4: begin
               rsp_valid <= 1'b1;
               state     <= ST_RSP;
            end
            ST_RSP:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_z80_io_master.sv
// ============================================================================
//  Module   : tb_z80_io_master
//  Brief    : Directed self-checking bench for z80_io_master (N_WAIT 0 and 2).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_z80_io_master;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid0 = 1'b0, req_valid2 = 1'b0;
   logic [1:0] req_op = 2'b00;
   logic [3:0] req_addr = '0;
   logic [7:0] req_wdata = '0;
   logic [7:0] din = '0;
   logic       int_n = 1'b1;
   logic       wait_n = 1'b1;

   logic       rdy0, rv0, ip0, m10, io0, rd0, wr0, oe0;
   logic [7:0] rdat0, dout0;
   logic [3:0] a0;
   logic       rdy2, rv2, ip2, m12, io2, rd2, wr2, oe2;
   logic [7:0] rdat2, dout2;
   logic [3:0] a2;

   int checks = 0;
   int failures = 0;

   logic [15:0] m1m, iom, rdm, wrm, oem, rvm, rdym;
   logic [7:0]  dat [16];
   logic [7:0]  dd  [16];
   logic [3:0]  aa  [16];

   always #5 clk = ~clk;

   z80_io_master #(.AWID(4), .DWID(8), .N_WAIT(0)) u_dut0 (
      .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(rdy0),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv0), .rsp_data(rdat0), .int_pending(ip0),
      .m1_n(m10), .iorq_n(io0), .rd_n(rd0), .wr_n(wr0),
      .a(a0), .dout(dout0), .dout_oe(oe0), .din(din), .int_n(int_n), .wait_n(wait_n)
   );

   z80_io_master #(.AWID(4), .DWID(8), .N_WAIT(2)) u_dut2 (
      .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(rdy2),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv2), .rsp_data(rdat2), .int_pending(ip2),
      .m1_n(m12), .iorq_n(io2), .rd_n(rd2), .wr_n(wr2),
      .a(a2), .dout(dout2), .dout_oe(oe2), .din(din), .int_n(int_n), .wait_n(wait_n)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Cycle k = period after edge k-1, acceptance edge = edge 0; sampled mid-cycle.
   // wlo / rmask give the cycles in which wait_n is low / reset is high.
   task automatic run_txn(input int sel, input logic [1:0] op, input logic [3:0] addr,
                          input logic [7:0] wd, input logic [15:0] wlo, input logic [15:0] rmask);
      @(negedge clk);
      req_op = op; req_addr = addr; req_wdata = wd;
      if (sel == 0) req_valid0 = 1'b1; else req_valid2 = 1'b1;
      @(posedge clk);
      #1;
      req_valid0 = 1'b0; req_valid2 = 1'b0;
      req_op = 2'b00; req_addr = '0; req_wdata = '0;
      m1m = '0; iom = '0; rdm = '0; wrm = '0; oem = '0; rvm = '0; rdym = '0;
      for (int k = 1; k < 16; k++) begin
         @(negedge clk);
         m1m[k]  = (sel == 0) ? ~m10 : ~m12;
         iom[k]  = (sel == 0) ? ~io0 : ~io2;
         rdm[k]  = (sel == 0) ? ~rd0 : ~rd2;
         wrm[k]  = (sel == 0) ? ~wr0 : ~wr2;
         oem[k]  = (sel == 0) ? oe0  : oe2;
         rvm[k]  = (sel == 0) ? rv0  : rv2;
         rdym[k] = (sel == 0) ? rdy0 : rdy2;
         dat[k]  = (sel == 0) ? rdat0 : rdat2;
         dd[k]   = (sel == 0) ? dout0 : dout2;
         aa[k]   = (sel == 0) ? a0 : a2;
         wait_n  = ~wlo[k];
         reset   = rmask[k];
      end
      wait_n = 1'b1;
      reset  = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_val("rst_strobes", {m10, io0, rd0, wr0}, 32'hF);
      check_val("rst_a_dout_oe", {a0, dout0, oe0}, 32'h0);
      check_val("rst_rsp", {rv0, rdat0}, 32'h0);
      check_val("rst_int_ready", {ip0, rdy0}, 32'h1);

      // I/O write, N_WAIT=0
      run_txn(0, 2'b01, 4'h3, 8'hA5, 16'h0, 16'h0);
      check_val("wr_iorq_low", iom, 32'h001C);
      check_val("wr_wr_low", wrm, 32'h001C);
      check_val("wr_rd_m1_low", rdm | m1m, 32'h0);
      check_val("wr_oe", oem, 32'h001E);
      check_val("wr_dout_a", {dd[2], aa[1]}, {20'h0, 8'hA5, 4'h3});
      check_val("wr_rsp_cycle", rvm, 32'h0020);
      check_val("wr_rsp_data", dat[5], 32'h0);
      check_val("wr_ready", rdym, 32'hFFC0);

      // I/O read, N_WAIT=2
      din = 8'h5C;
      run_txn(2, 2'b00, 4'hA, 8'h00, 16'h0, 16'h0);
      check_val("rd2_rd_low", rdm, 32'h007C);
      check_val("rd2_iorq_low", iom, 32'h007C);
      check_val("rd2_rsp_cycle", rvm, 32'h0080);
      check_val("rd2_rsp_data", dat[7], 32'h5C);
      check_val("rd2_addr", aa[3], 32'hA);

      // INTA, N_WAIT=0
      din = 8'h48;
      run_txn(0, 2'b10, 4'h7, 8'h00, 16'h0, 16'h0);
      check_val("inta_m1_low", m1m, 32'h003E);
      check_val("inta_iorq_low", iom, 32'h0038);
      check_val("inta_rd_wr_low", rdm | wrm, 32'h0);
      check_val("inta_rsp_cycle", rvm, 32'h0080);
      check_val("inta_rsp_data", dat[7], 32'h48);
      check_val("inta_addr", aa[3], 32'h0);

      // I/O read with wait_n low at the samples ending cycles 3..5
      din = 8'h91;
      run_txn(0, 2'b00, 4'h1, 8'h00, 16'h0038, 16'h0);
`ifdef Z80IO_WAIT_EN
      check_val("wait_rd_low", rdm, 32'h00FC);
      check_val("wait_rsp_cycle", rvm, 32'h0100);
      check_val("wait_rsp_data", dat[8], 32'h91);
`else
      check_val("wait_rd_low", rdm, 32'h001C);
      check_val("wait_rsp_cycle", rvm, 32'h0020);
      check_val("wait_rsp_data", dat[5], 32'h91);
`endif

      // Reset during cycle 3 of an I/O write
      run_txn(0, 2'b01, 4'h5, 8'h3C, 16'h0, 16'h0008);
      check_val("rstmid_wr_low", wrm, 32'h000C);
      check_val("rstmid_oe", oem, 32'h000E);
      check_val("rstmid_no_rsp", rvm, 32'h0);
      check_val("rstmid_ready_c4", rdym[4], 32'h1);

      // Reserved op
      run_txn(0, 2'b11, 4'hF, 8'h00, 16'h0, 16'h0);
      check_val("rsvd_rsp_cycle", rvm, 32'h0002);
      check_val("rsvd_rsp_data", dat[1], 32'hFF);
      check_val("rsvd_no_strobes", m1m | iom | rdm | wrm | oem, 32'h0);
      check_val("rsvd_ready", rdym[3:1], 32'h6);

      // int_n synchroniser latency
      @(negedge clk);
      int_n = 1'b0;
      @(posedge clk);
      #1;
      check_val("int_after_1", ip0, 32'h0);
      @(posedge clk);
      #1;
      check_val("int_after_2", {ip0, ip2}, 32'h3);
      int_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("int_release", ip0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
